// File: rtl/bomb_countdown.sv
// Countdown "bomb" game controller: arms on start, counts seconds down,
// and resolves to defused (safe wire cut) or exploded (wrong wire or timeout).
module bomb_countdown #(
    parameter int TICK_DIV  = 50,
    parameter int START_SEC = 30,
    parameter int SAFE_WIRE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] wire_cut,
    input  logic       repeat_rst,
    output logic       fail,
    output logic       win,
    output logic       armed,
    output logic [5:0] secs,
    output logic       beep_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [5:0]    START_V   = 6'(START_SEC);
    localparam logic [3:0]    SAFE_MASK = 4'b0001 << SAFE_WIRE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2,
        WON    = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] pre_r;
    logic [3:0]    wire_prev_r;

    logic [3:0] cut_ev_s;
    logic       tick_s;
    logic       timeout_s;
    logic       wrong_cut_s;
    logic       safe_cut_s;

    // Edge-detect wire cuts and decode the second tick / game events.
    always_comb begin
        cut_ev_s    = wire_cut & ~wire_prev_r;
        tick_s      = (pre_r == PRE_MAX);
        timeout_s   = tick_s && (secs == 6'd1);
        wrong_cut_s = |(cut_ev_s & ~SAFE_MASK);
        safe_cut_s  = |(cut_ev_s & SAFE_MASK);
    end

    // Game FSM with all outputs held in registers.
    always_ff @(posedge clk) begin
        wire_prev_r <= wire_cut;
        beep_tick   <= 1'b0;
        if (rst) begin
            state_r <= IDLE;
            pre_r   <= '0;
            secs    <= START_V;
            fail    <= 1'b0;
            win     <= 1'b0;
            armed   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pre_r <= '0;
                    secs  <= START_V;
                    fail  <= 1'b0;
                    win   <= 1'b0;
                    if (start && (wire_cut == 4'b0000)) begin
                        state_r <= ARMED;
                        armed   <= 1'b1;
                    end else begin
                        armed   <= 1'b0;
                    end
                end
                ARMED: begin
                    if (tick_s) begin
                        pre_r     <= '0;
                        beep_tick <= 1'b1;
                        if (secs != 6'd0) begin
                            secs <= secs - 6'd1;
                        end else begin
                            secs <= secs;
                        end
                    end else begin
                        pre_r <= pre_r + PW'(1);
                    end
                    // Explosion wins over defusal when both happen together.
                    if (wrong_cut_s || timeout_s) begin
                        state_r <= FAILED;
                        fail    <= 1'b1;
                        armed   <= 1'b0;
                    end else if (safe_cut_s) begin
                        state_r <= WON;
                        win     <= 1'b1;
                        armed   <= 1'b0;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                FAILED: begin
                    if (repeat_rst) begin
                        state_r <= IDLE;
                        fail    <= 1'b0;
                        secs    <= START_V;
                        pre_r   <= '0;
                    end else begin
                        state_r <= FAILED;
                    end
                end
                WON: begin
                    if (start || repeat_rst) begin
                        state_r <= IDLE;
                        win     <= 1'b0;
                        secs    <= START_V;
                        pre_r   <= '0;
                    end else begin
                        state_r <= WON;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pre_r   <= '0;
                    secs    <= START_V;
                    fail    <= 1'b0;
                    win     <= 1'b0;
                    armed   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown with TICK_DIV=4, START_SEC=3, SAFE_WIRE=2.
module tb_bomb_countdown;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] wire_cut = 4'b0000;
    logic       repeat_rst = 1'b0;
    logic       fail;
    logic       win;
    logic       armed;
    logic [5:0] secs;
    logic       beep_tick;

    int errors = 0;
    int checks = 0;

    bomb_countdown #(.TICK_DIV(4), .START_SEC(3), .SAFE_WIRE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .wire_cut(wire_cut),
        .repeat_rst(repeat_rst), .fail(fail), .win(win), .armed(armed),
        .secs(secs), .beep_tick(beep_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int f, input int w, input int a, input int s);
        chk({tag, ".fail"}, int'(fail), f);
        chk({tag, ".win"}, int'(win), w);
        chk({tag, ".armed"}, int'(armed), a);
        chk({tag, ".secs"}, int'(secs), s);
    endtask

    initial begin
        // Reset
        step(2);
        chk_flags("reset", 0, 0, 0, 3);
        chk("reset.beep", int'(beep_tick), 0);
        rst = 1'b0;
        step(1);

        // Timeout; repeat_rst while armed must be ignored
        start = 1'b1;
        step(1);
        chk_flags("arm", 0, 0, 1, 3);
        start = 1'b0;
        repeat_rst = 1'b1;
        step(3);
        chk("to.beep0", int'(beep_tick), 0);
        chk_flags("to.rr_ignored", 0, 0, 1, 3);
        repeat_rst = 1'b0;
        step(1);
        chk("to.beep1", int'(beep_tick), 1);
        chk("to.secs2", int'(secs), 2);
        step(1);
        chk("to.beep_len", int'(beep_tick), 0);
        step(3);
        chk("to.beep2", int'(beep_tick), 1);
        chk("to.secs1", int'(secs), 1);
        step(4);
        chk_flags("to.expl", 1, 0, 0, 0);
        step(3);
        chk_flags("to.frozen", 1, 0, 0, 0);
        repeat_rst = 1'b1;
        step(1);
        chk_flags("to.restore", 0, 0, 0, 3);
        repeat_rst = 1'b0;

        // Defuse at secs=2, then leave WON with start held and a wire still cut
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        chk("df.secs2", int'(secs), 2);
        wire_cut = 4'b0100;
        step(1);
        chk_flags("df.won", 0, 1, 0, 2);
        step(5);
        chk_flags("df.hold", 0, 1, 0, 2);
        start = 1'b1;
        step(1);
        chk_flags("df.leave", 0, 0, 0, 3);
        step(1);
        chk_flags("df.blocked", 0, 0, 0, 3);
        wire_cut = 4'b0000;
        step(1);
        chk_flags("df.rearm", 0, 0, 1, 3);
        start = 1'b0;

        // Wrong cut, then further cuts and start ignored
        wire_cut = 4'b0001;
        step(1);
        chk_flags("wc.expl", 1, 0, 0, 3);
        wire_cut = 4'b0111;
        start = 1'b1;
        step(2);
        chk_flags("wc.ignore", 1, 0, 0, 3);
        start = 1'b0;
        wire_cut = 4'b0000;
        repeat_rst = 1'b1;
        step(1);
        chk_flags("wc.restore", 0, 0, 0, 3);
        repeat_rst = 1'b0;

        // Simultaneous safe + wrong cut
        start = 1'b1;
        step(1);
        start = 1'b0;
        wire_cut = 4'b0110;
        step(1);
        chk_flags("sim.both", 1, 0, 0, 3);
        wire_cut = 4'b0000;
        repeat_rst = 1'b1;
        step(1);
        repeat_rst = 1'b0;

        // Safe cut coincident with the 1->0 tick
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(11);
        chk("sim.secs1", int'(secs), 1);
        wire_cut = 4'b0100;
        step(1);
        chk_flags("sim.timeout", 1, 0, 0, 0);
        wire_cut = 4'b0000;
        repeat_rst = 1'b1;
        step(1);
        repeat_rst = 1'b0;

        // Arm blocked by a cut wire
        wire_cut = 4'b1000;
        start = 1'b1;
        step(2);
        chk_flags("blk.idle", 0, 0, 0, 3);
        wire_cut = 4'b0000;
        step(1);
        chk_flags("blk.arm", 0, 0, 1, 3);
        start = 1'b0;

        // Reset on the edge that would time out
        step(11);
        chk("rr.secs1", int'(secs), 1);
        rst = 1'b1;
        step(1);
        chk_flags("rr.idle", 0, 0, 0, 3);
        chk("rr.beep", int'(beep_tick), 0);
        rst = 1'b0;
        step(5);
        chk_flags("rr.stay", 0, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
